// File: rtl/utx_pkg.sv
// Shared constants for the UART transmit buffer: FSM encoding, oversampling
// rate and default frame geometry.
package utx_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  localparam int OVERSAMPLE      = 16;
  localparam int DBIT_DEFAULT    = 8;
  localparam int SB_TICK_DEFAULT = 16;

endpackage

// File: rtl/utx_hold.sv
// One-byte holding register between the core write strobe and the serializer.
// A write is taken only while empty; the serializer empties it with clr.
module utx_hold #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr,
  input  logic [W-1:0] datain,
  input  logic         clr,
  output logic [W-1:0] hold,
  output logic         full
);

  logic [W-1:0] hold_q, hold_d;
  logic         full_q, full_d;

  // clr is only raised while full, so it can never collide with an accepted write.
  always_comb begin
    hold_d = hold_q;
    full_d = full_q;
    if (clr) full_d = 1'b0;
    if (wr && !full_q) begin
      hold_d = datain;
      full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_q <= '0;
      full_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      full_q <= full_d;
    end
  end

  assign hold = hold_q;
  assign full = full_q;

endmodule

// File: rtl/utx_buffer.sv
// UART transmitter: holding register plus 8N1 serializer driven by a 16x tick.
// Handshake: wr is a single-cycle strobe, accepted only when full=0 at the edge.
module utx_buffer
  import utx_pkg::*;
#(
  parameter int DBIT    = DBIT_DEFAULT,
  parameter int SB_TICK = SB_TICK_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            s_tick,
  input  logic            wr,
  input  logic [DBIT-1:0] datain,
  output logic            tx,
  output logic            full,
  output logic            busy,
  output logic            tx_done_tick,
  output logic [1:0]      dbg_state
);

  localparam logic [3:0] S_LAST  = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] SB_LAST = 4'(SB_TICK - 1);
  localparam logic [2:0] N_LAST  = 3'(DBIT - 1);

  logic [1:0]      state_q, state_d;
  logic [3:0]      s_q, s_d;
  logic [2:0]      n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic            tx_q, tx_d;
  logic            done_q, done_d;
  logic            hold_clr;
  logic [DBIT-1:0] hold_data;

  utx_hold #(.W(DBIT)) u_hold (
    .clk    (clk),
    .rst    (rst),
    .wr     (wr),
    .datain (datain),
    .clr    (hold_clr),
    .hold   (hold_data),
    .full   (full)
  );

  always_comb begin
    state_d  = state_q;
    s_d      = s_q;
    n_d      = n_q;
    b_d      = b_q;
    done_d   = 1'b0;
    hold_clr = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A tick coinciding with the load is deliberately not counted.
        if (full) begin
          b_d      = hold_data;
          hold_clr = 1'b1;
          s_d      = '0;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        if (s_tick) begin
          if (s_q == S_LAST) begin
            s_d     = '0;
            n_d     = '0;
            state_d = ST_DATA;
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end
      ST_DATA: begin
        if (s_tick) begin
          if (s_q == S_LAST) begin
            s_d = '0;
            b_d = b_q >> 1;
            if (n_q == N_LAST) state_d = ST_STOP;
            else               n_d     = n_q + 3'd1;
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end
      default: begin
        if (s_tick) begin
          if (s_q == SB_LAST) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end
    endcase

    // tx is registered from the next state so the line changes with the state.
    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = b_d[0];
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  assign tx           = tx_q;
  assign busy         = (state_q != ST_IDLE);
  assign tx_done_tick = done_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_utx_buffer.sv
// Bench for utx_buffer: directed scenarios plus random bytes, with a line-level
// frame decoder and an expected-byte queue as the reference.
module tb_utx_buffer;

  localparam int DBIT        = 8;
  localparam int SB_TICK     = 16;
  localparam int OS          = 16;
  localparam int FRAME_TICKS = (1 + DBIT) * OS + SB_TICK;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       s_tick = 1'b0;
  logic       wr = 1'b0;
  logic [7:0] datain = 8'h00;
  logic       tx, full, busy, tx_done_tick;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] data;
    int         len;
    logic       start_bit;
    logic       stop_bit;
    logic       glitch;
    int         gap;
  } frame_t;
  frame_t rx_q[$];

  utx_buffer #(.DBIT(DBIT), .SB_TICK(SB_TICK)) dut (
    .clk          (clk),
    .rst          (rst),
    .s_tick       (s_tick),
    .wr           (wr),
    .datain       (datain),
    .tx           (tx),
    .full         (full),
    .busy         (busy),
    .tx_done_tick (tx_done_tick),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / tick generation ----------------
  always #5 clk = ~clk;

  bit tick_en  = 1'b1;
  int tick_div = 0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (tick_en) begin
        tick_div = (tick_div + 1) % 4;
        s_tick   = (tick_div == 0);
      end else begin
        s_tick = 1'b0;
      end
    end
  end

  // ---------------- line decoder (reference receiver) ----------------
  bit         framing = 1'b0;
  int         mon_t = 0;
  int         idle_cnt = 1000;
  int         gap_saved = 0;
  int         done_cnt = 0;
  int         frames_total = 0;
  int         idx = 0;
  int         prev_idx = -1;
  logic       prev_tx = 1'b1;
  logic [9:0] bits = '1;
  logic       glitch = 1'b0;
  frame_t     mf;

  always @(negedge clk) begin
    if (!rst) begin
      framing  = 1'b0;
      mon_t    = 0;
      idle_cnt = 1000;
    end else begin
      if (tx_done_tick === 1'b1) done_cnt++;
      if (framing && tx_done_tick === 1'b1) begin
        mf.data      = bits[8:1];
        mf.len       = mon_t;
        mf.start_bit = bits[0];
        mf.stop_bit  = bits[9];
        mf.glitch    = glitch;
        mf.gap       = gap_saved;
        rx_q.push_back(mf);
        frames_total++;
        framing  = 1'b0;
        idle_cnt = 1;
      end else if (framing || tx === 1'b0) begin
        if (!framing) begin
          framing   = 1'b1;
          mon_t     = 0;
          bits      = '1;
          glitch    = 1'b0;
          gap_saved = idle_cnt;
          prev_idx  = -1;
        end
        idx = mon_t / OS;
        if (idx < 10) begin
          if (idx == prev_idx && tx !== prev_tx) glitch = 1'b1;
          bits[idx] = tx;
        end else begin
          glitch = 1'b1;
        end
        prev_idx = idx;
        prev_tx  = tx;
        if (s_tick) mon_t++;
      end else if (idle_cnt < 1000) begin
        idle_cnt++;
      end
    end
  end

  // ---------------- driver / checker tasks ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    assert (got === expv) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, expv);
    end
  endtask

  task automatic do_write(input logic [7:0] b);
    @(negedge clk);
    wr     = 1'b1;
    datain = b;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic expect_frame(input string tag, input int exp_gap);
    int     cnt;
    frame_t f;
    logic [7:0] e;
    cnt = 0;
    while (rx_q.size() == 0 && cnt < 1500) begin
      @(negedge clk);
      cnt++;
    end
    check({tag, "_arrived"}, 32'(rx_q.size() > 0), 32'd1);
    check({tag, "_expected"}, 32'(exp_q.size() > 0), 32'd1);
    if (rx_q.size() > 0 && exp_q.size() > 0) begin
      f = rx_q.pop_front();
      e = exp_q.pop_front();
      check({tag, "_data"}, 32'(f.data), 32'(e));
      check({tag, "_len"}, 32'(f.len), 32'(FRAME_TICKS));
      check({tag, "_start"}, 32'(f.start_bit), 32'd0);
      check({tag, "_stop"}, 32'(f.stop_bit), 32'd1);
      check({tag, "_stable"}, 32'(f.glitch), 32'd0);
      if (exp_gap >= 0) check({tag, "_gap"}, 32'(f.gap), 32'(exp_gap));
    end
  endtask

  task automatic wait_bit(input int lo, input int hi);
    int cnt;
    cnt = 0;
    while (!(framing && mon_t >= lo && mon_t < hi) && cnt < 1500) begin
      @(negedge clk);
      cnt++;
    end
    check("bit_window_reached", 32'(cnt < 1500), 32'd1);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int         dc;
    int         mt;
    int         cnt;
    logic [7:0] rb;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(tx_done_tick), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // Single byte A5 and load latency
    do_write(8'hA5);
    exp_q.push_back(8'hA5);
    check("single_full_set", 32'(full), 32'd1);
    check("single_busy_before", 32'(busy), 32'd0);
    check("single_tx_idle", 32'(tx), 32'd1);
    @(negedge clk);
    check("single_full_clr", 32'(full), 32'd0);
    check("single_busy", 32'(busy), 32'd1);
    check("single_tx_start", 32'(tx), 32'd0);
    expect_frame("single", -1);
    check("single_done_cnt", 32'(done_cnt), 32'd1);
    repeat (10) @(negedge clk);
    check("single_idle_busy", 32'(busy), 32'd0);

    // Back-to-back 55 then 0F
    do_write(8'h55);
    exp_q.push_back(8'h55);
    repeat (6) @(negedge clk);
    check("b2b_busy", 32'(busy), 32'd1);
    check("b2b_full_clr", 32'(full), 32'd0);
    do_write(8'h0F);
    exp_q.push_back(8'h0F);
    check("b2b_full_set", 32'(full), 32'd1);
    expect_frame("b2b_a", -1);
    expect_frame("b2b_b", 1);
    repeat (10) @(negedge clk);

    // Overrun: 03 is dropped
    do_write(8'h01);
    exp_q.push_back(8'h01);
    do_write(8'h02);
    exp_q.push_back(8'h02);
    check("ovr_full_02", 32'(full), 32'd1);
    do_write(8'h03);
    check("ovr_full_03", 32'(full), 32'd1);
    wait_bit(100, 140);
    check("ovr_full_mid", 32'(full), 32'd1);
    expect_frame("ovr_a", -1);
    expect_frame("ovr_b", 1);
    repeat (800) @(negedge clk);
    check("ovr_no_extra", 32'(rx_q.size()), 32'd0);
    check("ovr_exp_empty", 32'(exp_q.size()), 32'd0);

    // Reset during data bit 3 with a pending byte
    do_write(8'hF0);
    wait_bit(68, 72);
    do_write(8'h3C);
    check("mrst_pending", 32'(full), 32'd1);
    check("mrst_tx_before", 32'(tx), 32'd0);
    dc = done_cnt;
    #2 rst = 1'b0;
    #1;
    check("mrst_tx", 32'(tx), 32'd1);
    check("mrst_full", 32'(full), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_state", 32'(dbg_state), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    check("mrst_no_done", 32'(done_cnt), 32'(dc));
    check("mrst_no_frame", 32'(rx_q.size()), 32'd0);
    check("mrst_discarded", 32'(full), 32'd0);
    check("mrst_idle", 32'(busy), 32'd0);
    do_write(8'hC3);
    exp_q.push_back(8'hC3);
    expect_frame("after_rst", -1);
    repeat (10) @(negedge clk);

    // Tick gap in the stop bit
    do_write(8'h96);
    exp_q.push_back(8'h96);
    wait_bit(148, 152);
    tick_en = 1'b0;
    repeat (2) @(negedge clk);
    dc = done_cnt;
    mt = mon_t;
    repeat (50) @(negedge clk);
    check("gap_state", 32'(dbg_state), 32'd3);
    check("gap_tx", 32'(tx), 32'd1);
    check("gap_busy", 32'(busy), 32'd1);
    check("gap_no_done", 32'(done_cnt), 32'(dc));
    check("gap_frozen", 32'(mon_t), 32'(mt));
    tick_en = 1'b1;
    expect_frame("gap", -1);
    repeat (10) @(negedge clk);

    // Random bytes streamed with flow control
    for (int i = 0; i < 6; i++) begin
      cnt = 0;
      while (full !== 1'b0 && cnt < 1500) begin
        @(negedge clk);
        cnt++;
      end
      check("rand_full_wait", 32'(cnt < 1500), 32'd1);
      rb = 8'($urandom_range(0, 255));
      do_write(rb);
      exp_q.push_back(rb);
    end
    for (int i = 0; i < 6; i++) begin
      expect_frame("rand", (i == 0) ? -1 : 1);
    end
    repeat (20) @(negedge clk);
    check("done_per_frame", 32'(done_cnt), 32'(frames_total));
    check("final_idle", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
